// File: rtl/ahb_lite_master_arbiter.sv
`timescale 1ns/1ps
// Two-master AHB-Lite arbiter. Each master has a hold stage that captures a
// pending address phase and stalls that master until the phase is issued.
//   state   | meaning
//   DP_NONE | no data phase in flight
//   DP_M0   | M0 owns the current data phase
//   DP_M1   | M1 owns the current data phase
module ahb_lite_master_arbiter #(
  parameter bit ROUND_ROBIN = 1'b0,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] M0_HADDR,
  input  logic [1:0]            M0_HTRANS,
  input  logic                  M0_HWRITE,
  input  logic [2:0]            M0_HSIZE,
  input  logic [2:0]            M0_HBURST,
  input  logic [3:0]            M0_HPROT,
  input  logic                  M0_HMASTLOCK,
  input  logic [31:0]           M0_HWDATA,
  output logic                  M0_HREADY,
  output logic [31:0]           M0_HRDATA,
  output logic                  M0_HRESP,
  input  logic [ADDR_WIDTH-1:0] M1_HADDR,
  input  logic [1:0]            M1_HTRANS,
  input  logic                  M1_HWRITE,
  input  logic [2:0]            M1_HSIZE,
  input  logic [2:0]            M1_HBURST,
  input  logic [3:0]            M1_HPROT,
  input  logic                  M1_HMASTLOCK,
  input  logic [31:0]           M1_HWDATA,
  output logic                  M1_HREADY,
  output logic [31:0]           M1_HRDATA,
  output logic                  M1_HRESP,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [31:0]           HWDATA,
  input  logic                  HREADY,
  input  logic [31:0]           HRDATA,
  input  logic                  HRESP,
  output logic                  HMASTER
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  lock;
  } aph_t;

  typedef enum logic [1:0] {
    DP_NONE = 2'd0,
    DP_M0   = 2'd1,
    DP_M1   = 2'd2
  } dp_state_t;

  aph_t      live [2];
  aph_t      held [2];
  aph_t      eff  [2];
  aph_t      bus;
  logic [1:0] hold_valid;
  logic [1:0] hold_load;
  logic [1:0] hold_clr;
  logic [1:0] mready;
  logic [1:0] req;
  logic       last_owner;
  logic       prio;
  logic       grant;
  logic       keep;
  dp_state_t  dp_state;
  dp_state_t  dp_next;

  assign live[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK};
  assign live[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK};

  // A held master is stalled; otherwise it sees the slave only while it owns the data phase.
  assign mready[0] = hold_valid[0] ? 1'b0 : ((dp_state == DP_M0) ? HREADY : 1'b1);
  assign mready[1] = hold_valid[1] ? 1'b0 : ((dp_state == DP_M1) ? HREADY : 1'b1);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eff[i] = live[i];
      if (hold_valid[i]) begin
        eff[i] = held[i];
      end else if (!mready[i]) begin
        eff[i].trans = TR_IDLE;
      end
      req[i] = eff[i].trans[1];
    end
  end

  always_comb begin
    keep  = 1'b0;
    grant = last_owner;
    if (HREADY) begin
      keep = (eff[last_owner].trans == TR_SEQ) || (eff[last_owner].trans == TR_BUSY) ||
             eff[last_owner].lock;
      if (!keep) begin
        if (req[prio]) begin
          grant = prio;
        end else if (req[~prio]) begin
          grant = ~prio;
        end
      end
    end
  end

  // Parked with no request: the owner's effective trans is already IDLE here.
  assign bus = eff[grant];

  assign hold_load[0] = mready[0] & live[0].trans[1] & (grant | ~HREADY);
  assign hold_load[1] = mready[1] & live[1].trans[1] & (~grant | ~HREADY);
  assign hold_clr[0]  = hold_valid[0] & HREADY & ~grant;
  assign hold_clr[1]  = hold_valid[1] & HREADY & grant;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hold_valid <= '0;
      held[0]    <= '0;
      held[1]    <= '0;
      last_owner <= 1'b0;
      prio       <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (hold_clr[i]) begin
          hold_valid[i] <= 1'b0;
        end else if (hold_load[i]) begin
          hold_valid[i] <= 1'b1;
          held[i]       <= live[i];
        end
      end
      if (HREADY) begin
        last_owner <= grant;
      end
      if (ROUND_ROBIN && HREADY && (bus.trans == TR_NONSEQ)) begin
        prio <= ~grant;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_state <= DP_NONE;
    end else begin
      dp_state <= dp_next;
    end
  end

  always_comb begin
    dp_next = dp_state;
    if (HREADY) begin
      if (!bus.trans[1]) begin
        dp_next = DP_NONE;
      end else if (grant) begin
        dp_next = DP_M1;
      end else begin
        dp_next = DP_M0;
      end
    end
  end

  always_comb begin
    HWDATA = '0;
    case (dp_state)
      DP_M0:   HWDATA = M0_HWDATA;
      DP_M1:   HWDATA = M1_HWDATA;
      default: HWDATA = '0;
    endcase
  end

  assign HADDR     = bus.addr;
  assign HTRANS    = bus.trans;
  assign HWRITE    = bus.write;
  assign HSIZE     = bus.size;
  assign HBURST    = bus.burst;
  assign HPROT     = bus.prot;
  assign HMASTLOCK = bus.lock;
  assign HMASTER   = grant;

  assign M0_HREADY = mready[0];
  assign M1_HREADY = mready[1];
  assign M0_HRDATA = (dp_state == DP_M0) ? HRDATA : '0;
  assign M1_HRDATA = (dp_state == DP_M1) ? HRDATA : '0;
  assign M0_HRESP  = (dp_state == DP_M0) ? HRESP : 1'b0;
  assign M1_HRESP  = (dp_state == DP_M1) ? HRESP : 1'b0;

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
`timescale 1ns/1ps
// Directed bench: a fixed-priority and a round-robin arbiter share all inputs.
module tb_ahb_lite_master_arbiter;

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic        M0_HMASTLOCK, M1_HMASTLOCK;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HMASTER;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  logic        rr_m0_hready, rr_m1_hready, rr_m0_hresp, rr_m1_hresp;
  logic [31:0] rr_m0_hrdata, rr_m1_hrdata;
  logic [31:0] rr_haddr, rr_hwdata;
  logic [1:0]  rr_htrans;
  logic        rr_hwrite, rr_hmastlock, rr_hmaster;
  logic [2:0]  rr_hsize, rr_hburst;
  logic [3:0]  rr_hprot;

  int n_vec = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master_arbiter #(.ROUND_ROBIN(1'b0), .ADDR_WIDTH(32)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA), .M1_HRESP(M1_HRESP),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .HMASTER(HMASTER)
  );

  ahb_lite_master_arbiter #(.ROUND_ROBIN(1'b1), .ADDR_WIDTH(32)) u_dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(rr_m0_hready), .M0_HRDATA(rr_m0_hrdata), .M0_HRESP(rr_m0_hresp),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(rr_m1_hready), .M1_HRDATA(rr_m1_hrdata), .M1_HRESP(rr_m1_hresp),
    .HADDR(rr_haddr), .HTRANS(rr_htrans), .HWRITE(rr_hwrite), .HSIZE(rr_hsize), .HBURST(rr_hburst),
    .HPROT(rr_hprot), .HMASTLOCK(rr_hmastlock), .HWDATA(rr_hwdata),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .HMASTER(rr_hmaster)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic m0_drv(input logic [1:0] tr, input logic [31:0] a);
    M0_HTRANS = tr;
    M0_HADDR  = a;
  endtask

  task automatic m1_drv(input logic [1:0] tr, input logic [31:0] a);
    M1_HTRANS = tr;
    M1_HADDR  = a;
  endtask

  initial begin
    HRESETn = 1'b0;
    m0_drv(IDLE, 32'h0); m1_drv(IDLE, 32'h0);
    M0_HWRITE = 1'b0; M1_HWRITE = 1'b0;
    M0_HSIZE = 3'd2; M1_HSIZE = 3'd2;
    M0_HBURST = 3'd0; M1_HBURST = 3'd0;
    M0_HPROT = 4'h3; M1_HPROT = 4'h3;
    M0_HMASTLOCK = 1'b0; M1_HMASTLOCK = 1'b0;
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
    HREADY = 1'b1; HRDATA = 32'hFFFF_FFFF; HRESP = 1'b1;
    tick(); tick();
    HRESETn = 1'b1;

    // reset state
    settle();
    chk("rst_hmaster", HMASTER, 1'b0);
    chk("rst_htrans", HTRANS, IDLE);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hmastlock", HMASTLOCK, 1'b0);
    chk("rst_m0_hready", M0_HREADY, 1'b1);
    chk("rst_m1_hready", M1_HREADY, 1'b1);
    chk("rst_m0_hrdata", M0_HRDATA, 32'h0);
    chk("rst_m0_hresp", M0_HRESP, 1'b0);
    chk("rst_m1_hresp", M1_HRESP, 1'b0);
    tick();
    HRDATA = 32'h0; HRESP = 1'b0;

    // M0 single read on idle bus
    m0_drv(NSEQ, 32'h10);
    settle();
    chk("rd_haddr", HADDR, 32'h10);
    chk("rd_htrans", HTRANS, NSEQ);
    chk("rd_hmaster", HMASTER, 1'b0);
    chk("rd_m1_hready_a", M1_HREADY, 1'b1);
    tick();
    m0_drv(IDLE, 32'h0); HRDATA = 32'h1234_5678;
    settle();
    chk("rd_m0_hrdata", M0_HRDATA, 32'h1234_5678);
    chk("rd_m0_hready", M0_HREADY, 1'b1);
    chk("rd_m1_hrdata", M1_HRDATA, 32'h0);
    chk("rd_m1_hready_d", M1_HREADY, 1'b1);
    tick();
    HRDATA = 32'h0;

    // simultaneous NONSEQ, fixed priority; slave waits once on the M1 data phase
    m0_drv(NSEQ, 32'h100); m1_drv(NSEQ, 32'h200);
    settle();
    chk("sim_haddr_0", HADDR, 32'h100);
    chk("sim_hmaster_0", HMASTER, 1'b0);
    chk("sim_m1_hready_0", M1_HREADY, 1'b1);
    tick();
    m0_drv(IDLE, 32'h0); m1_drv(IDLE, 32'h0);
    settle();
    chk("sim_haddr_1", HADDR, 32'h200);
    chk("sim_htrans_1", HTRANS, NSEQ);
    chk("sim_hmaster_1", HMASTER, 1'b1);
    chk("sim_m1_hready_1", M1_HREADY, 1'b0);
    chk("sim_m0_hready_1", M0_HREADY, 1'b1);
    tick();
    HREADY = 1'b0;
    settle();
    chk("sim_m1_hready_2", M1_HREADY, 1'b0);
    chk("sim_htrans_2", HTRANS, IDLE);
    tick();
    HREADY = 1'b1; HRDATA = 32'hCAFE_0200;
    settle();
    chk("sim_m1_hready_3", M1_HREADY, 1'b1);
    chk("sim_m1_hrdata", M1_HRDATA, 32'hCAFE_0200);
    chk("sim_m0_hrdata", M0_HRDATA, 32'h0);
    chk("sim_no_replay", HTRANS, IDLE);
    tick();
    HRDATA = 32'h0;

    // M1 INCR4 burst with M0 requesting mid-burst
    m1_drv(NSEQ, 32'h2000); M1_HBURST = 3'd3;
    settle();
    chk("bst_hmaster_0", HMASTER, 1'b1);
    chk("bst_haddr_0", HADDR, 32'h2000);
    chk("bst_hburst", HBURST, 3'd3);
    tick();
    m1_drv(SEQ, 32'h2004); m0_drv(NSEQ, 32'h300);
    settle();
    chk("bst_hmaster_1", HMASTER, 1'b1);
    chk("bst_haddr_1", HADDR, 32'h2004);
    chk("bst_htrans_1", HTRANS, SEQ);
    chk("bst_m0_hready_1", M0_HREADY, 1'b1);
    tick();
    m1_drv(SEQ, 32'h2008); m0_drv(IDLE, 32'h0);
    settle();
    chk("bst_hmaster_2", HMASTER, 1'b1);
    chk("bst_haddr_2", HADDR, 32'h2008);
    chk("bst_m0_hready_2", M0_HREADY, 1'b0);
    tick();
    m1_drv(SEQ, 32'h200C);
    settle();
    chk("bst_hmaster_3", HMASTER, 1'b1);
    chk("bst_haddr_3", HADDR, 32'h200C);
    tick();
    m1_drv(IDLE, 32'h0); M1_HBURST = 3'd0;
    settle();
    chk("bst_m0_grant", HMASTER, 1'b0);
    chk("bst_m0_haddr", HADDR, 32'h300);
    chk("bst_m0_htrans", HTRANS, NSEQ);
    tick();
    HRDATA = 32'hB0B0_0300;
    settle();
    chk("bst_m0_hrdata", M0_HRDATA, 32'hB0B0_0300);
    chk("bst_m0_hready", M0_HREADY, 1'b1);
    chk("bst_htrans_end", HTRANS, IDLE);
    tick();
    HRDATA = 32'h0;

    // M0 write with two wait states while M1 requests
    m0_drv(NSEQ, 32'h400); M0_HWRITE = 1'b1;
    settle();
    chk("wr_hwrite", HWRITE, 1'b1);
    chk("wr_hmaster", HMASTER, 1'b0);
    tick();
    m0_drv(IDLE, 32'h0); M0_HWRITE = 1'b0; M0_HWDATA = 32'hDEAD_BEEF;
    HREADY = 1'b0; m1_drv(NSEQ, 32'h500);
    settle();
    chk("wr_hwdata_0", HWDATA, 32'hDEAD_BEEF);
    chk("wr_m0_hready_0", M0_HREADY, 1'b0);
    chk("wr_m1_hready_0", M1_HREADY, 1'b1);
    chk("wr_htrans_0", HTRANS, IDLE);
    tick();
    m1_drv(IDLE, 32'h0);
    settle();
    chk("wr_hwdata_1", HWDATA, 32'hDEAD_BEEF);
    chk("wr_m1_hready_1", M1_HREADY, 1'b0);
    chk("wr_m0_hready_1", M0_HREADY, 1'b0);
    tick();
    HREADY = 1'b1;
    settle();
    chk("wr_hwdata_2", HWDATA, 32'hDEAD_BEEF);
    chk("wr_m1_haddr", HADDR, 32'h500);
    chk("wr_m1_hmaster", HMASTER, 1'b1);
    chk("wr_m0_hready_2", M0_HREADY, 1'b1);
    chk("wr_m1_hready_2", M1_HREADY, 1'b0);
    tick();
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h1111_0500;
    settle();
    chk("wr_hwdata_m1", HWDATA, 32'h1111_0500);
    chk("wr_m1_hready_3", M1_HREADY, 1'b1);
    chk("wr_htrans_end", HTRANS, IDLE);
    tick();
    M1_HWDATA = 32'h0;

    // reset while M1 is held
    m0_drv(NSEQ, 32'h600); m1_drv(NSEQ, 32'h700);
    settle();
    chk("rh_hmaster", HMASTER, 1'b0);
    chk("rh_haddr", HADDR, 32'h600);
    tick();
    m0_drv(IDLE, 32'h0); m1_drv(IDLE, 32'h0); HRESETn = 1'b0;
    settle();
    chk("rh_m1_held", M1_HREADY, 1'b0);
    tick();
    HRESETn = 1'b1;
    settle();
    chk("rh_htrans", HTRANS, IDLE);
    chk("rh_hmaster_0", HMASTER, 1'b0);
    chk("rh_m0_hready", M0_HREADY, 1'b1);
    chk("rh_m1_hready", M1_HREADY, 1'b1);
    tick();
    settle();
    chk("rh_no_replay", HTRANS, IDLE);
    chk("rh_m1_hready_1", M1_HREADY, 1'b1);
    tick();

    // continuous singles from both: round-robin alternates, fixed priority keeps M0
    m0_drv(NSEQ, 32'h800); m1_drv(NSEQ, 32'h900);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("rr_hmaster_%0d", c), rr_hmaster, c[0]);
      chk($sformatf("rr_haddr_%0d", c), rr_haddr, c[0] ? 32'h900 : 32'h800);
      chk($sformatf("fp_hmaster_%0d", c), HMASTER, 1'b0);
      tick();
    end
    m0_drv(IDLE, 32'h0); m1_drv(IDLE, 32'h0);
    tick(); tick(); tick();

    // two-cycle ERROR response goes only to the owner
    m0_drv(NSEQ, 32'hA00);
    settle();
    chk("err_hmaster", HMASTER, 1'b0);
    tick();
    m0_drv(IDLE, 32'h0); HREADY = 1'b0; HRESP = 1'b1;
    settle();
    chk("err_m0_hresp_0", M0_HRESP, 1'b1);
    chk("err_m0_hready_0", M0_HREADY, 1'b0);
    chk("err_m1_hresp", M1_HRESP, 1'b0);
    chk("err_m1_hready", M1_HREADY, 1'b1);
    tick();
    HREADY = 1'b1;
    settle();
    chk("err_m0_hresp_1", M0_HRESP, 1'b1);
    chk("err_m0_hready_1", M0_HREADY, 1'b1);
    tick();
    HRESP = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
